ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Drives the head of the configuration flip-flop chain that runs through the grid tiles: ccff_head in, ccff_tail out.
- Accepts bitstream words over a valid/ready stream and serialises them onto ccff_head.
- Issues a clock-enable so the chain shifts only on cycles carrying valid data.
- Also runs a chain-integrity test: it injects a single marker bit, watches ccff_tail and reports the measured chain length.

Parameters:
- CHAIN_LEN, 64, total configuration bits in the chain (≥2).
- WORD_W, 8, bitstream word width.
- CNT_W, 16, width of the bit/length counters; must hold 2*CHAIN_LEN.

Ports:
- prog_clk  input  1  programming clock.
- pReset  input  1  asynchronous, active-high reset.
- start  input  1  pulse: begin a load of CHAIN_LEN bits.
- test_start  input  1  pulse: begin the integrity test.
- word_data  input  WORD_W  bitstream word; MSB is shifted first.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  loader accepts word_data this cycle.
- ccff_head  output  1  serial bit into the chain.
- ccff_tail  input  1  serial bit out of the chain end.
- prog_clk_en  output  1  enable for the chain's gated prog_clk; the chain shifts on each prog_clk edge where this is 1.
- busy  output  1  state not IDLE.
- done  output  1  one-cycle pulse when a load or test completes.
- test_fail  output  1  sticky; set when a test measures a length other than CHAIN_LEN or times out; cleared by the next start or test_start.
- measured_len  output  CNT_W  length from the last test; 0 on timeout.

Behaviour:
- Reset: the clock is prog_clk and the reset is pReset, asynchronous and active-high. Reset drives state to IDLE and clears every output: word_ready, ccff_head, prog_clk_en, busy, done, test_fail and measured_len are all 0. The word buffer and counters are cleared. Reset mid-load or mid-test aborts with no done pulse, and the chain contents are undefined.
- FSM states: IDLE, LOAD, T_FLUSH, T_INJECT, T_WATCH, FINISH.
- IDLE:
  - start → LOAD.
  - test_start → T_FLUSH.
  - If both are asserted in the same cycle, start wins.
  - start and test_start are ignored while busy.
- LOAD:
  - One-word buffer with a bit index; bits_left is initialised to CHAIN_LEN.
  - word_ready = (buffer empty OR last buffered bit shifting this cycle) AND words still needed. Words needed = ceil(CHAIN_LEN/WORD_W) minus words accepted.
  - A word is accepted on word_valid & word_ready, at zero bubble back-to-back.
  - ccff_head = buffer[current bit], combinational from registers. prog_clk_en = buffer non-empty.
  - On each enabled cycle, bits_left decrements.
  - On the final word, bits beyond bits_left are discarded and never shifted.
  - bits_left reaching 0 → FINISH.
  - An empty buffer stalls with prog_clk_en = 0; the chain holds.
- T_FLUSH:
  - ccff_head = 0, prog_clk_en = 1, for exactly CHAIN_LEN cycles → T_INJECT.
- T_INJECT:
  - One cycle: ccff_head = 1, prog_clk_en = 1.
  - The counter is set to 1 → T_WATCH.
- T_WATCH:
  - ccff_head = 0, prog_clk_en = 1.
  - Each cycle, ccff_tail is sampled first:
    - If it is 1: measured_len ← counter; test_fail ← (counter ≠ CHAIN_LEN); → FINISH with prog_clk_en = 0 that cycle.
    - Otherwise the counter increments.
  - If the counter reaches 2*CHAIN_LEN with no marker: measured_len ← 0, test_fail ← 1, → FINISH.
- FINISH: done = 1 for one cycle; prog_clk_en = 0; → IDLE.
- After a test, chain contents are all-zero except possibly the marker. A reload is required before use.
- word_ready is 0 outside LOAD. word_valid outside LOAD is ignored and not consumed.
- Latency: ccff_head presents a bit in the same cycle as its prog_clk_en; no pipeline stage.

Decomposition:
- Shared package ccff_loader_pkg: FSM state enum, and localparams WORDS_NEEDED = ceil(CHAIN_LEN/WORD_W) and TIMEOUT = 2*CHAIN_LEN.
- One natural sub-module: ccff_word_serializer, holding the word buffer, bit index, empty flag and word_ready/ccff_head generation. The top keeps the FSM, counters and test logic.

Test Plan:
- Load with CHAIN_LEN=64, WORD_W=8: 8 back-to-back words 0xA5… with word_valid held high → exactly 64 prog_clk_en cycles with no gaps. The chain model holds the words in MSB-first order. One done pulse; word_ready never high after the 8th accept.
- Stall: word_valid low for 5 cycles after word 3 → prog_clk_en low for those cycles and the chain is unchanged. Total enabled cycles stay 64.
- Partial word with CHAIN_LEN=60: 8 words accepted, 60 enabled cycles. The last 4 LSBs of word 8 never appear on ccff_head.
- Integrity test against a 64-FF chain model → 64 flush cycles, 1 inject, marker observed with measured_len=64, test_fail=0, done pulse.
- Broken chain (model of 63 FFs, or ccff_tail stuck at 0) → measured_len=63 with test_fail=1. For the stuck case, timeout after 128 counts with measured_len=0 and test_fail=1.
- pReset asserted mid-LOAD at bit 30 → all outputs 0 asynchronously. After release, start reloads the full 64 bits correctly. start and test_start asserted together in IDLE → LOAD entered.

Source files
------------

// File: rtl/ccff_chain_loader_pkg.sv
// Shared definitions for the configuration chain loader: FSM state
// encoding, default sizing and the helpers that derive word/timeout counts.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    T_FLUSH,
    T_INJECT,
    T_WATCH,
    FINISH
  } state_t;

  localparam int DEF_CHAIN_LEN = 64;
  localparam int DEF_WORD_W    = 8;
  localparam int DEF_CNT_W     = 16;

  // Number of bitstream words needed to cover the whole chain.
  function automatic int words_needed(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Integrity test gives up after twice the nominal chain length.
  function automatic int timeout_count(input int chain_len);
    return 2 * chain_len;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Valid/ready word stream carrying bitstream words into the loader.
interface ccff_chain_loader_if import ccff_loader_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W
);

  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/ccff_word_serializer.sv
// One-word buffer that accepts bitstream words and presents them MSB first
// on the chain head, requesting the next word while the last bit shifts out.
module ccff_word_serializer import ccff_loader_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              active,
  input  logic              more_words,
  input  logic              last_bit,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              full,
  output logic              head
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] buffer;
  logic [IDX_W-1:0]  bit_idx;
  logic              accept;
  logic              shift;

  assign word_ready = active & more_words & (~full | (bit_idx == '0));
  assign accept     = word_valid & word_ready;
  assign shift      = active & full;
  assign head       = full ? buffer[bit_idx] : 1'b0;

  // Buffer fill/drain: a new word may land in the same cycle the previous
  // word's last bit shifts, so the stream runs without bubbles.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      buffer  <= '0;
      bit_idx <= '0;
      full    <= 1'b0;
    end else if (!active) begin
      full <= 1'b0;
    end else if (accept) begin
      buffer  <= word_data;
      bit_idx <= IDX_W'(WORD_W - 1);
      full    <= 1'b1;
    end else if (shift) begin
      if ((bit_idx == '0) || last_bit) begin
        full <= 1'b0;
      end else begin
        bit_idx <= bit_idx - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Drives the head of the configuration flip-flop chain: serialises a
// bitstream into it, or runs a marker-based chain length measurement.
module ccff_chain_loader import ccff_loader_pkg::*; #(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                start,
  input  logic                test_start,
  ccff_chain_loader_if.slave  word_if,
  output logic                ccff_head,
  input  logic                ccff_tail,
  output logic                prog_clk_en,
  output logic                busy,
  output logic                done,
  output logic                test_fail,
  output logic [CNT_W-1:0]    measured_len
);

  localparam int WORDS_NEEDED = words_needed(CHAIN_LEN, WORD_W);
  localparam int TIMEOUT      = timeout_count(CHAIN_LEN);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] bits_left;
  logic [CNT_W-1:0] words_acc;
  logic [CNT_W-1:0] counter;
  logic             ser_full;
  logic             ser_head;
  logic             word_accept;

  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);
  assign word_accept = word_if.word_valid & word_if.word_ready;

  ccff_word_serializer #(.WORD_W(WORD_W)) u_serializer (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .active     (state == LOAD),
    .more_words (words_acc < CNT_W'(WORDS_NEEDED)),
    .last_bit   (bits_left == CNT_W'(1)),
    .word_data  (word_if.word_data),
    .word_valid (word_if.word_valid),
    .word_ready (word_if.word_ready),
    .full       (ser_full),
    .head       (ser_head)
  );

  // State register.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and chain drive; the marker is checked before the counter
  // advances so a marker seen at the timeout count still reports a length.
  always_comb begin
    next_state  = state;
    ccff_head   = 1'b0;
    prog_clk_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LOAD;
        end else if (test_start) begin
          next_state = T_FLUSH;
        end
      end
      LOAD: begin
        ccff_head   = ser_head;
        prog_clk_en = ser_full;
        if (ser_full && (bits_left == CNT_W'(1))) begin
          next_state = FINISH;
        end
      end
      T_FLUSH: begin
        prog_clk_en = 1'b1;
        if (counter == CNT_W'(CHAIN_LEN - 1)) begin
          next_state = T_INJECT;
        end
      end
      T_INJECT: begin
        ccff_head   = 1'b1;
        prog_clk_en = 1'b1;
        next_state  = T_WATCH;
      end
      T_WATCH: begin
        if (ccff_tail || (counter == CNT_W'(TIMEOUT))) begin
          next_state = FINISH;
        end else begin
          prog_clk_en = 1'b1;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Bit/word/test counters and the test result registers.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      bits_left    <= '0;
      words_acc    <= '0;
      counter      <= '0;
      measured_len <= '0;
      test_fail    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bits_left <= CNT_W'(CHAIN_LEN);
            words_acc <= '0;
            test_fail <= 1'b0;
          end else if (test_start) begin
            counter   <= '0;
            test_fail <= 1'b0;
          end
        end
        LOAD: begin
          if (ser_full) begin
            bits_left <= bits_left - 1'b1;
          end
          if (word_accept) begin
            words_acc <= words_acc + 1'b1;
          end
        end
        T_FLUSH: begin
          counter <= counter + 1'b1;
        end
        T_INJECT: begin
          counter <= CNT_W'(1);
        end
        T_WATCH: begin
          if (ccff_tail) begin
            measured_len <= counter;
            test_fail    <= (counter != CNT_W'(CHAIN_LEN));
          end else if (counter == CNT_W'(TIMEOUT)) begin
            measured_len <= '0;
            test_fail    <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for the chain loader: two instances (64- and 60-bit chains) each
// feeding a behavioural shift-register model of the configuration chain.
module tb_ccff_chain_loader;

  logic       prog_clk = 1'b0;
  logic       pReset   = 1'b1;
  logic [1:0] start_v, test_start_v, valid_v, ready_v, head_v, tail_v;
  logic [1:0] en_v, busy_v, done_v, fail_v, stuck_v;
  logic [7:0]   data_a  [2];
  logic [15:0]  mlen_a  [2];
  logic [127:0] chain_a [2];
  logic [6:0]   tap_a   [2];
  int vec_count  = 0;
  int miss_count = 0;

  // Free-running programming clock.
  always #5 prog_clk = ~prog_clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    ccff_chain_loader_if #(.WORD_W(8)) wif ();
    assign wif.word_data  = data_a[g];
    assign wif.word_valid = valid_v[g];
    assign ready_v[g]     = wif.word_ready;
    assign tail_v[g]      = stuck_v[g] ? 1'b0 : chain_a[g][tap_a[g]];

    ccff_chain_loader #(.CHAIN_LEN(g == 0 ? 64 : 60), .WORD_W(8), .CNT_W(16)) dut (
      .prog_clk     (prog_clk),
      .pReset       (pReset),
      .start        (start_v[g]),
      .test_start   (test_start_v[g]),
      .word_if      (wif),
      .ccff_head    (head_v[g]),
      .ccff_tail    (tail_v[g]),
      .prog_clk_en  (en_v[g]),
      .busy         (busy_v[g]),
      .done         (done_v[g]),
      .test_fail    (fail_v[g]),
      .measured_len (mlen_a[g])
    );
  end

  // Chain model: bit 0 is the FF nearest the head, shifts on enabled edges.
  always @(posedge prog_clk) begin
    for (int g = 0; g < 2; g++) begin
      if (en_v[g]) chain_a[g] <= {chain_a[g][126:0], head_v[g]};
    end
  end

  function automatic int lenOf(input int g);
    return (g == 0) ? 64 : 60;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkReset(input int g);
    checkOutput("rst_word_ready", ready_v[g], 0);
    checkOutput("rst_ccff_head", head_v[g], 0);
    checkOutput("rst_prog_clk_en", en_v[g], 0);
    checkOutput("rst_busy", busy_v[g], 0);
    checkOutput("rst_done", done_v[g], 0);
    checkOutput("rst_test_fail", fail_v[g], 0);
    checkOutput("rst_measured_len", mlen_a[g], 0);
  endtask

  // One load: random words (first is A5), optional stall/random gaps, an
  // optional simultaneous test_start, optional reset abort after abort_at bits.
  task automatic applyStimulus(input int g, input int stall_after, input int stall_len,
                               input bit rand_gaps, input bit also_test,
                               input int abort_at, input bit poke_busy);
    logic [7:0]   words[$];
    bit           exp_bits[$];
    logic [127:0] ev, mask;
    int n, needed, acc, shifted, cyc, stall_cnt, first_en, last_en, avail;
    bit done_seen, finish_next, offer;
    n = lenOf(g);
    needed = (n + 7) / 8;
    acc = 0; shifted = 0; cyc = 0; stall_cnt = 0; first_en = -1; last_en = -1;
    done_seen = 0; finish_next = 0;
    for (int w = 0; w < needed; w++) words.push_back((w == 0) ? 8'hA5 : 8'($urandom));
    for (int w = 0; w < needed; w++)
      for (int b = 7; b >= 0; b--)
        if (exp_bits.size() < n) exp_bits.push_back(words[w][b]);
    @(negedge prog_clk);
    start_v[g] = 1'b1;
    test_start_v[g] = also_test;
    @(negedge prog_clk);
    start_v[g] = 1'b0;
    test_start_v[g] = 1'b0;
    while (!done_seen && cyc < 600) begin
      start_v[g]      = poke_busy && (cyc == 10);
      test_start_v[g] = poke_busy && (cyc == 20);
      offer = (acc < needed);
      if (acc == stall_after && stall_cnt < stall_len) begin
        offer = 0;
        stall_cnt++;
      end
      if (rand_gaps && $urandom_range(0, 3) == 0) offer = 0;
      valid_v[g] = offer;
      if (offer) data_a[g] = words[acc];
      else data_a[g] = 8'($urandom);
      #1;
      avail = ((acc * 8 < n) ? acc * 8 : n) - shifted;
      checkOutput("prog_clk_en", en_v[g], avail > 0);
      checkOutput("word_ready", ready_v[g], (acc < needed) && (avail <= 1));
      checkOutput("done", done_v[g], finish_next);
      checkOutput("busy", busy_v[g], 1);
      if (done_v[g]) done_seen = 1;
      finish_next = 0;
      if (en_v[g]) begin
        checkOutput("shift_in_range", shifted < n, 1);
        if (shifted < n) checkOutput("ccff_head", head_v[g], exp_bits[shifted]);
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        shifted++;
        if (shifted == n) finish_next = 1;
        if (abort_at > 0 && shifted == abort_at) begin
          #2 pReset = 1'b1;
          #1 checkReset(g);
          valid_v[g] = 1'b0;
          start_v[g] = 1'b0;
          test_start_v[g] = 1'b0;
          @(negedge prog_clk);
          pReset = 1'b0;
          return;
        end
      end
      if (valid_v[g] && ready_v[g]) acc++;
      @(negedge prog_clk);
      cyc++;
    end
    valid_v[g] = 1'b0;
    start_v[g] = 1'b0;
    test_start_v[g] = 1'b0;
    #1;
    checkOutput("load_done_seen", done_seen, 1);
    checkOutput("bits_shifted", shifted, n);
    if (stall_len == 0 && !rand_gaps) checkOutput("no_gaps", last_en - first_en + 1, n);
    ev = '0;
    for (int k = 0; k < n; k++) ev[k] = exp_bits[n - 1 - k];
    mask = (128'd1 << n) - 128'd1;
    checkOutput("chain_contents", chain_a[g] & mask, ev);
    checkOutput("idle_after_load", busy_v[g], 0);
    checkOutput("test_fail_cleared", fail_v[g], 0);
  endtask

  // Integrity test against a chain model of len FFs (or a stuck tail).
  task automatic runTest(input int g, input int len, input bit stuck,
                         input int exp_len, input bit exp_fail);
    int flush, inject, watch, cyc;
    bit done_seen;
    flush = 0; inject = 0; watch = 0; cyc = 0; done_seen = 0;
    tap_a[g]   = 7'(len - 1);
    stuck_v[g] = stuck;
    @(negedge prog_clk);
    test_start_v[g] = 1'b1;
    @(negedge prog_clk);
    test_start_v[g] = 1'b0;
    while (!done_seen && cyc < 1000) begin
      #1;
      if (done_v[g]) done_seen = 1;
      else if (inject > 0) watch++;
      else if (en_v[g] && head_v[g]) inject++;
      else if (en_v[g]) flush++;
      @(negedge prog_clk);
      cyc++;
    end
    #1;
    checkOutput("test_done_seen", done_seen, 1);
    checkOutput("flush_cycles", flush, lenOf(g));
    checkOutput("inject_cycles", inject, 1);
    checkOutput("watch_cycles", watch, stuck ? 2 * lenOf(g) : len);
    checkOutput("measured_len", mlen_a[g], exp_len);
    checkOutput("test_fail", fail_v[g], exp_fail);
    checkOutput("idle_after_test", busy_v[g], 0);
    stuck_v[g] = 1'b0;
  endtask

  initial begin
    start_v = '0; test_start_v = '0; valid_v = '0; stuck_v = '0;
    data_a[0] = '0; data_a[1] = '0;
    tap_a[0] = 7'd63; tap_a[1] = 7'd59;
    #12;
    checkReset(0);
    checkReset(1);
    @(negedge prog_clk);
    pReset = 1'b0;
    $display("[TB] back-to-back load, 64-bit chain");
    applyStimulus(0, -1, 0, 0, 0, 0, 0);
    $display("[TB] stalled load after word 3");
    applyStimulus(0, 3, 5, 0, 0, 0, 0);
    $display("[TB] partial final word, 60-bit chain");
    applyStimulus(1, -1, 0, 0, 0, 0, 0);
    $display("[TB] integrity tests");
    runTest(0, 63, 0, 63, 1);
    runTest(0, 64, 1, 0, 1);
    runTest(1, 60, 0, 60, 0);
    runTest(0, 64, 0, 64, 0);
    $display("[TB] reset mid-load at bit 30, then reload");
    applyStimulus(0, -1, 0, 0, 0, 30, 0);
    applyStimulus(0, -1, 0, 0, 0, 0, 0);
    $display("[TB] start and test_start together");
    applyStimulus(0, -1, 0, 0, 1, 0, 0);
    $display("[TB] random gap loads with ignored pulses");
    for (int r = 0; r < 4; r++) applyStimulus(r % 2, -1, 0, 1, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
